fifo_weights_prog: RTL and testbench
====================================

FIFO_WEIGHTS_PROG -- requirements
Module: fifo_weights_prog

Interface
REQ-001 Parameter WIDTH, default 128, data word width in bits.
REQ-002 Parameter DEPTH, default 44, storage entries; any integer 2..1024, not necessarily a power of two.
REQ-003 Parameter FWFT, default 1, read mode: 1 = first-word-fall-through, 0 = standard registered read.
REQ-004 Parameter CNT_W, default $clog2(DEPTH+1), width of occupancy and threshold ports.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 srst  input  1  synchronous, active-high reset.
REQ-007 din  input  WIDTH  write data.
REQ-008 wr_en  input  1  write request.
REQ-009 rd_en  input  1  read request (FWFT=1: acknowledge of the word on dout).
REQ-010 prog_full_thresh  input  CNT_W  programmable full threshold, sampled every cycle.
REQ-011 prog_empty_thresh  input  CNT_W  programmable empty threshold, sampled every cycle.
REQ-012 dout  output  WIDTH  read data.
REQ-013 valid  output  1  dout holds a popped or presented word.
REQ-014 full / empty  output  1 each  occupancy == DEPTH / no word available on read side.
REQ-015 prog_full / prog_empty  output  1 each  threshold flags.
REQ-016 data_count  output  CNT_W  words written and not yet popped, 0..DEPTH.
REQ-017 overflow / underflow  output  1 each  one-cycle error pulses.

Function
REQ-018 Write accepted iff wr_en && !full; din stored at write pointer, which wraps DEPTH-1 -> 0.
REQ-019 Read accepted iff rd_en && !empty; read pointer wraps DEPTH-1 -> 0.
REQ-020 data_count registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-021 Simultaneous wr_en && rd_en when full: read accepted, write rejected, overflow asserted.
REQ-022 Simultaneous wr_en && rd_en when empty: write accepted, read rejected, underflow asserted.
REQ-023 full = (data_count == DEPTH); prog_full = (data_count >= prog_full_thresh); prog_empty = (data_count <= prog_empty_thresh); all combinational from registered data_count.
REQ-024 FWFT=0: empty = (data_count == 0); dout and valid update the cycle after an accepted read; valid is a one-cycle pulse; dout holds its last value otherwise.
REQ-025 FWFT=1: first write into an empty FIFO at cycle t -> empty=0, valid=1, dout=that word at cycle t+1; valid == !empty at all times.
REQ-026 FWFT=1: accepted read at cycle t -> next word on dout at t+1, or empty=1 at t+1 if none; back-to-back reads sustain one word per cycle.
REQ-027 overflow registered: 1 in cycle t+1 iff wr_en && full at cycle t; underflow likewise for rd_en && empty.
REQ-028 Rejected operations never alter contents, pointers or data_count.
REQ-029 Sustained throughput: one write and one read per cycle concurrently, with no bubbles at pointer wrap.

Reset
REQ-030 srst high at a rising edge: pointers=0, data_count=0, dout=0, valid=0, empty=1, full=0, overflow=0, underflow=0; prog flags follow REQ-023 with data_count=0.
REQ-031 wr_en and rd_en are ignored while srst is high; reset mid-operation discards all stored words; the first write after release behaves as a write into an empty FIFO.

Verification
REQ-032 DEPTH=44, FWFT=1: write 0x01..0x2C on consecutive cycles -> full=1 after the 44th write; data_count=44; 45th write -> overflow pulse, contents unchanged.
REQ-033 FWFT=1: single write 0xAB into empty at t -> dout=0xAB, valid=1, empty=0 at t+1; read at t+1 -> empty=1 at t+2.
REQ-034 FWFT=0: write 0x5, read at t -> dout=0x5, valid=1 at t+1 only; read while empty -> underflow pulse, dout unchanged.
REQ-035 prog_full_thresh=40, prog_empty_thresh=3: fill to 39 -> prog_full=0, 40 -> 1; drain to 4 -> prog_empty=0, 3 -> 1.
REQ-036 Fill 30, then simultaneous read+write for 100 cycles -> data_count stays 30, output order matches write order across pointer wrap.
REQ-037 Fill 20, assert srst one cycle with wr_en=1 -> empty=1, data_count=0 next cycle; the next written word is the next word read.

Source files
------------

// File: rtl/fifo_weights_prog.sv
// Synchronous FIFO with programmable full/empty thresholds, selectable
// first-word-fall-through or registered read, and overflow/underflow pulses.
module fifo_weights_prog #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 44,
    parameter int FWFT  = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [CNT_W-1:0] prog_full_thresh,
    input  logic [CNT_W-1:0] prog_empty_thresh,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic             prog_full,
    output logic             prog_empty,
    output logic [CNT_W-1:0] data_count,
    output logic             overflow,
    output logic             underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] rd_data_p0;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign prog_full  = (count >= prog_full_thresh);
    assign prog_empty = (count <= prog_empty_thresh);
    assign data_count = count;

    // A read frees a slot only in the following cycle, so a full FIFO rejects
    // a concurrent write; an empty one likewise rejects a concurrent read.
    assign wr_ok      = wr_en && !full;
    assign rd_ok      = rd_en && !empty;
    assign rd_data_p0 = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok && !srst)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rd_ok)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented straight from storage; blank when empty.
            assign valid = !empty;
            assign dout  = empty ? '0 : rd_data_p0;
        end else begin : g_std
            logic [WIDTH-1:0] dout_p1;
            logic             vld_p1;

            // Stage p1: registered read data, held between accepted reads.
            always_ff @(posedge clk) begin
                if (srst) begin
                    dout_p1 <= '0;
                    vld_p1  <= 1'b0;
                end else begin
                    vld_p1 <= rd_ok;
                    if (rd_ok)
                        dout_p1 <= rd_data_p0;
                end
            end

            assign dout  = dout_p1;
            assign valid = vld_p1;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_weights_prog.sv
// Randomized self-checking bench: a FWFT DEPTH=44 FIFO and a registered-read
// DEPTH=5 FIFO share one stimulus stream and are compared to queue models.
module tb_fifo_weights_prog;
    localparam int W   = 16;
    localparam int DA  = 44;
    localparam int DB  = 5;
    localparam int CWA = $clog2(DA + 1);
    localparam int CWB = $clog2(DB + 1);

    logic           clk = 1'b0;
    logic           srst = 1'b1;
    logic [W-1:0]   din = '0;
    logic           wr_en = 1'b0;
    logic           rd_en = 1'b0;
    logic [CWA-1:0] pft_a = CWA'(40);
    logic [CWA-1:0] pet_a = CWA'(3);
    logic [CWB-1:0] pft_b = CWB'(4);
    logic [CWB-1:0] pet_b = CWB'(1);

    logic [W-1:0]   dout_a, dout_b;
    logic           valid_a, full_a, empty_a, pf_a, pe_a, ov_a, un_a;
    logic           valid_b, full_b, empty_b, pf_b, pe_b, ov_b, un_b;
    logic [CWA-1:0] cnt_a;
    logic [CWB-1:0] cnt_b;

    fifo_weights_prog #(.WIDTH(W), .DEPTH(DA), .FWFT(1)) dut_a (
        .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .prog_full_thresh(pft_a), .prog_empty_thresh(pet_a),
        .dout(dout_a), .valid(valid_a), .full(full_a), .empty(empty_a),
        .prog_full(pf_a), .prog_empty(pe_a), .data_count(cnt_a),
        .overflow(ov_a), .underflow(un_a));

    fifo_weights_prog #(.WIDTH(W), .DEPTH(DB), .FWFT(0)) dut_b (
        .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .prog_full_thresh(pft_b), .prog_empty_thresh(pet_b),
        .dout(dout_b), .valid(valid_b), .full(full_b), .empty(empty_b),
        .prog_full(pf_b), .prog_empty(pe_b), .data_count(cnt_b),
        .overflow(ov_b), .underflow(un_b));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         exp_ov_a = 0, exp_un_a = 0, exp_ov_b = 0, exp_un_b = 0;
    logic         exp_vld_b = 0;
    logic [W-1:0] exp_dout_b = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour at one rising edge, from the inputs presented to it.
    task automatic model_edge();
        int na = qa.size();
        int nb = qb.size();
        if (srst) begin
            qa.delete(); qb.delete();
            exp_ov_a = 0; exp_un_a = 0; exp_ov_b = 0; exp_un_b = 0;
            exp_vld_b = 0; exp_dout_b = '0;
        end else begin
            exp_ov_a = wr_en && (na == DA);
            exp_un_a = rd_en && (na == 0);
            if (rd_en && na != 0) void'(qa.pop_front());
            if (wr_en && na != DA) qa.push_back(din);
            exp_ov_b  = wr_en && (nb == DB);
            exp_un_b  = rd_en && (nb == 0);
            exp_vld_b = rd_en && (nb != 0);
            if (exp_vld_b) exp_dout_b = qb.pop_front();
            if (wr_en && nb != DB) qb.push_back(din);
        end
    endtask

    task automatic check_all();
        int na = qa.size();
        int nb = qb.size();
        chk("a_count", 32'(cnt_a), 32'(na));
        chk("a_empty", 32'(empty_a), 32'(na == 0));
        chk("a_full", 32'(full_a), 32'(na == DA));
        chk("a_valid", 32'(valid_a), 32'(na != 0));
        chk("a_dout", 32'(dout_a), (na != 0) ? 32'(qa[0]) : 32'd0);
        chk("a_pfull", 32'(pf_a), 32'(na >= int'(pft_a)));
        chk("a_pempty", 32'(pe_a), 32'(na <= int'(pet_a)));
        chk("a_ovf", 32'(ov_a), 32'(exp_ov_a));
        chk("a_unf", 32'(un_a), 32'(exp_un_a));
        chk("b_count", 32'(cnt_b), 32'(nb));
        chk("b_empty", 32'(empty_b), 32'(nb == 0));
        chk("b_full", 32'(full_b), 32'(nb == DB));
        chk("b_valid", 32'(valid_b), 32'(exp_vld_b));
        chk("b_dout", 32'(dout_b), 32'(exp_dout_b));
        chk("b_pfull", 32'(pf_b), 32'(nb >= int'(pft_b)));
        chk("b_pempty", 32'(pe_b), 32'(nb <= int'(pet_b)));
        chk("b_ovf", 32'(ov_b), 32'(exp_ov_b));
        chk("b_unf", 32'(un_b), 32'(exp_un_b));
    endtask

    task automatic cyc(input logic w, input logic r, input logic [W-1:0] d, input logic rs);
        @(negedge clk);
        wr_en = w; rd_en = r; din = d; srst = rs;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    logic [W-1:0] seq;

    initial begin
        cyc(0, 0, '0, 1);
        cyc(1, 1, 16'h1234, 1);

        // Fill 1..44, overflow on the 45th, then drain through the thresholds.
        for (int i = 1; i <= DA; i++) cyc(1, 0, W'(i), 0);
        cyc(1, 0, 16'h002D, 0);
        cyc(0, 0, '0, 0);
        for (int i = 0; i < DA; i++) cyc(0, 1, '0, 0);
        cyc(0, 1, '0, 0);
        cyc(1, 1, 16'h0077, 0);

        // Single word through an empty FIFO.
        cyc(0, 1, '0, 0);
        cyc(1, 0, 16'h00AB, 0);
        cyc(0, 1, '0, 0);
        cyc(0, 0, '0, 0);

        // Fill 30 then steady-state read+write across pointer wrap.
        seq = 16'h1000;
        for (int i = 0; i < 30; i++) begin cyc(1, 0, seq, 0); seq++; end
        for (int i = 0; i < 100; i++) begin cyc(1, 1, seq, 0); seq++; end
        chk("steady_count", 32'(cnt_a), 32'd30);

        // Reset mid-operation with a write pending.
        for (int i = 0; i < 20; i++) cyc(1, 0, W'(16'h2000 + i), 0);
        cyc(1, 0, 16'hDEAD, 1);
        chk("rst_empty", 32'(empty_a), 32'd1);
        cyc(1, 0, 16'h0C0D, 0);
        chk("after_rst_head", 32'(dout_a), 32'h0C0D);
        cyc(0, 1, '0, 0);

        // Randomized phases with varying fill bias and thresholds.
        for (int ph = 0; ph < 12; ph++) begin
            int pw = $urandom_range(20, 80);
            int pr = $urandom_range(20, 80);
            pft_a = CWA'($urandom_range(0, DA));
            pet_a = CWA'($urandom_range(0, DA));
            pft_b = CWB'($urandom_range(0, DB));
            pet_b = CWB'($urandom_range(0, DB));
            for (int i = 0; i < 150; i++)
                cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                    W'($urandom), $urandom_range(0, 199) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
